// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, pixel/state types and test-bar colour helper
package vga_timing_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int H_FP        = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BP        = 48;
  localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE    = 480;
  localparam int V_FP        = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 33;
  localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SCALE_SHIFT = 2;
  localparam int PIX_W       = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {S_BLANK = 1'b0, S_SHOW = 1'b1} scan_state_e;

  function automatic rgb_t bar_rgb(input logic [2:0] idx);
    rgb_t c;
    c.r = {8{idx[2]}};
    c.g = {8{idx[1]}};
    c.b = {8{idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/still_frame_scanout_if.sv
// rtl/still_frame_scanout_if.sv - frame-buffer read port between scanout (master) and still store (slave)
interface still_frame_scanout_if #(
  parameter int PIX_W = 24
);
  logic             rd_en;
  logic [7:0]       rd_x;
  logic [7:0]       rd_y;
  logic [PIX_W-1:0] rd_data;

  modport master (output rd_en, output rd_x, output rd_y, input rd_data);
  modport slave  (input rd_en, input rd_x, input rd_y, output rd_data);
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - reusable h/v scan counters with active/sync/start-of-frame decode
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int CNT_W    = 10
) (
  input  logic             VGA_CLK,
  input  logic             reset,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs_n,
  output logic             vs_n,
  output logic             sof
);

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_n   = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vs_n   = !((v_cnt >= V_SS) && (v_cnt < V_SE));
  assign sof    = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/still_frame_scanout.sv
// rtl/still_frame_scanout.sv - upscaled still-frame VGA scanout; SCANOUT_TESTPATTERN_EN adds colour bars while blanked
module still_frame_scanout #(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int SCALE_SHIFT = vga_timing_pkg::SCALE_SHIFT,
  parameter int CNT_W       = 10
) (
  input  logic                  VGA_CLK,
  input  logic                  reset,
  input  logic                  show,
  still_frame_scanout_if.master fb,
  output logic                  oVGA_HS,
  output logic                  oVGA_VS,
  output logic                  oVGA_BLANK_N,
  output logic [7:0]            oVGA_R,
  output logic [7:0]            oVGA_G,
  output logic [7:0]            oVGA_B,
  output logic                  frame_start,
  output logic                  showing
);
  import vga_timing_pkg::*;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;
  logic             hs_n;
  logic             vs_n;
  logic             sof;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W(CNT_W)
  ) u_timing (
    .VGA_CLK(VGA_CLK), .reset(reset),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .active(active), .hs_n(hs_n), .vs_n(vs_n), .sof(sof)
  );

  scan_state_e state_q;
  scan_state_e state_eff;

  // The frame-start decision already governs pixel (0,0), so no frame is split between modes.
  assign state_eff = sof ? (show ? S_SHOW : S_BLANK) : state_q;

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state_q     <= S_BLANK;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_eff;
      frame_start <= sof;
    end
  end

  assign showing = (state_q == S_SHOW);

  logic act1, hs1, vs1, show1;
`ifdef SCANOUT_TESTPATTERN_EN
  logic [2:0] bar1;
`endif

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      fb.rd_en <= 1'b0;
      fb.rd_x  <= '0;
      fb.rd_y  <= '0;
      act1     <= 1'b0;
      hs1      <= 1'b1;
      vs1      <= 1'b1;
      show1    <= 1'b0;
    end else begin
      fb.rd_en <= active && (state_eff == S_SHOW);
      if (active) begin
        fb.rd_x <= 8'(h_cnt >> SCALE_SHIFT);
        fb.rd_y <= 8'(v_cnt >> SCALE_SHIFT);
      end
      act1  <= active;
      hs1   <= hs_n;
      vs1   <= vs_n;
      show1 <= (state_eff == S_SHOW);
    end
  end

`ifdef SCANOUT_TESTPATTERN_EN
  always_ff @(posedge VGA_CLK) begin
    if (reset) bar1 <= '0;
    else       bar1 <= 3'(h_cnt / CNT_W'(H_ACTIVE / 8));
  end
`endif

  logic sel_mem;
  rgb_t pat_q;
  rgb_t pix;

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
      sel_mem      <= 1'b0;
      pat_q        <= '0;
    end else begin
      oVGA_HS      <= hs1;
      oVGA_VS      <= vs1;
      oVGA_BLANK_N <= act1;
      sel_mem      <= act1 && show1;
`ifdef SCANOUT_TESTPATTERN_EN
      pat_q        <= (act1 && !show1) ? bar_rgb(bar1) : '0;
`else
      pat_q        <= '0;
`endif
    end
  end

  // The store's read register is the pixel register: its data lands in the BLANK_N cycle.
  assign pix    = sel_mem ? rgb_t'(fb.rd_data) : pat_q;
  assign oVGA_R = pix.r;
  assign oVGA_G = pix.g;
  assign oVGA_B = pix.b;

endmodule

// File: tb/tb_still_frame_scanout.sv
// tb/tb_still_frame_scanout.sv - scoreboard bench for still_frame_scanout on a reduced raster
module tb_still_frame_scanout;

  localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam int SS = 2;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic [23:0] rgb;
  } vid_t;

  localparam vid_t RST_VID = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, rgb: 24'h0};

  logic VGA_CLK = 1'b0;
  logic reset = 1'b1;
  logic show = 1'b0;
  logic oVGA_HS, oVGA_VS, oVGA_BLANK_N, frame_start, showing;
  logic [7:0] oVGA_R, oVGA_G, oVGA_B;

  still_frame_scanout_if #(.PIX_W(24)) fb ();

  still_frame_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SCALE_SHIFT(SS), .CNT_W(10)
  ) dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .show(show), .fb(fb),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .frame_start(frame_start), .showing(showing)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // Still store: registered read, word tagged with its own address.
  always @(posedge VGA_CLK) if (fb.rd_en) fb.rd_data <= {fb.rd_x, fb.rd_y, 8'h5A};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  int   hm = 0, vm = 0;
  logic st_show = 1'b0;
  logic [2:0] exp_ctl = 3'b000;
  logic eff_m;
  vid_t sb[$];

  assign eff_m = (hm == 0 && vm == 0) ? show : st_show;

  function automatic vid_t model_vid(input int h, input int v, input logic eff);
    vid_t e;
    logic act;
    act = (h < H_ACTIVE) && (v < V_ACTIVE);
    e.hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    e.vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    e.blank_n = act;
    e.rgb = 24'h0;
    if (act && eff) e.rgb = {8'(h >> SS), 8'(v >> SS), 8'h5A};
`ifdef SCANOUT_TESTPATTERN_EN
    else if (act) begin
      int i;
      i = h / (H_ACTIVE / 8);
      e.rgb = {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
    end
`endif
    return e;
  endfunction

  always @(posedge VGA_CLK) begin
    if (reset) begin
      hm <= 0;
      vm <= 0;
      st_show <= 1'b0;
      exp_ctl <= 3'b000;
      sb.delete();
      sb.push_back(RST_VID);
      sb.push_back(RST_VID);
    end else begin
      exp_ctl <= {hm == 0 && vm == 0, eff_m, (hm < H_ACTIVE) && (vm < V_ACTIVE) && eff_m};
      st_show <= eff_m;
      if (hm == H_TOTAL - 1) begin
        hm <= 0;
        vm <= (vm == V_TOTAL - 1) ? 0 : vm + 1;
      end else begin
        hm <= hm + 1;
      end
    end
  end

  always @(negedge VGA_CLK) begin
    vid_t e;
    check_eq("ctl", 32'({frame_start, showing, fb.rd_en}), 32'(exp_ctl));
    sb.push_back(model_vid(hm, vm, eff_m));
    if (sb.size() > 2) begin
      e = sb.pop_front();
      check_eq("vid", 32'({oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B}), 32'(e));
    end
  end

  function automatic logic sig(input int k);
    case (k)
      0:       return oVGA_HS;
      1:       return oVGA_VS;
      2:       return oVGA_BLANK_N;
      default: return frame_start;
    endcase
  endfunction

  task automatic wait_lvl(input int k, input logic lvl, output int n);
    n = 0;
    while (sig(k) !== lvl && n < 2 * FRAME) begin
      @(posedge VGA_CLK); #2;
      n++;
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(hm == h && vm == v) && n < 2 * FRAME) begin
      @(posedge VGA_CLK); #2;
      n++;
    end
    check_eq("wait_pos", 32'(hm == h && vm == v), 32'd1);
  endtask

  initial begin
    int n, low, rest, blank_hi, rden_hi, fs_cnt, hs_at;
    repeat (3) @(posedge VGA_CLK);
    #2;
    check_eq("rst_out", 32'({oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B,
                             frame_start, showing, fb.rd_en}), 32'({3'b110, 24'h0, 3'b000}));
    reset = 1'b0;

    wait_lvl(0, 1'b0, n);
    wait_lvl(0, 1'b1, low);
    wait_lvl(0, 1'b0, rest);
    check_eq("hs_low", 32'(low), 32'(H_SYNC));
    check_eq("hs_period", 32'(low + rest), 32'(H_TOTAL));

    wait_lvl(1, 1'b0, n);
    wait_lvl(1, 1'b1, low);
    wait_lvl(1, 1'b0, rest);
    check_eq("vs_low", 32'(low), 32'(V_SYNC * H_TOTAL));
    check_eq("vs_period", 32'(low + rest), 32'(FRAME));

    blank_hi = 0;
    rden_hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      blank_hi += int'(oVGA_BLANK_N);
      rden_hi += int'(fb.rd_en);
      @(posedge VGA_CLK); #2;
    end
    check_eq("blank_cnt", 32'(blank_hi), 32'(H_ACTIVE * V_ACTIVE));
    check_eq("rden_idle", 32'(rden_hi), 32'd0);

    show = 1'b1;
    wait_lvl(2, 1'b1, n);
    check_eq("first_pix", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h00005A);
    check_eq("showing_on", 32'(showing), 32'd1);
    repeat (4) @(posedge VGA_CLK);
    #2;
    check_eq("pix_h4", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h01005A);
    wait_lvl(2, 1'b0, n);
    wait_lvl(0, 1'b0, n);
    check_eq("blank_to_hs", 32'(n), 32'(H_FP));

    wait_pos(0, 12);
    show = 1'b0;
    @(posedge VGA_CLK); #2;
    check_eq("show_hold", 32'(showing), 32'd1);
    wait_lvl(3, 1'b1, n);
    check_eq("showing_off", 32'(showing), 32'd0);
    wait_lvl(2, 1'b1, n);
    check_eq("off_pix", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h0);

    wait_pos(30, 10);
    reset = 1'b1;
    @(posedge VGA_CLK); #2;
    check_eq("midrst_out", 32'({oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B,
                                frame_start, showing, fb.rd_en}), 32'({3'b110, 24'h0, 3'b000}));
    reset = 1'b0;
    fs_cnt = 0;
    hs_at = -1;
    for (int i = 0; i < 2 * H_TOTAL; i++) begin
      if (frame_start) fs_cnt++;
      if (!oVGA_HS && hs_at < 0) hs_at = i;
      @(posedge VGA_CLK); #2;
    end
    check_eq("restart_fs", 32'(fs_cnt), 32'd1);
    check_eq("restart_hs", 32'(hs_at), 32'(H_ACTIVE + H_FP + 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
